// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants: default 800x600@60 (40 MHz pixel clock) and the coordinate width.
// Also holds a small helper that sums the four regions of one axis into its total period.
package vga_timing_pkg;

  localparam int COORD_W     = 11;
  localparam int FRAME_CNT_W = 16;

  localparam int DEF_H_SYNC   = 128;
  localparam int DEF_H_BACK   = 88;
  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_H_FRONT  = 40;

  localparam int DEF_V_SYNC   = 4;
  localparam int DEF_V_BACK   = 23;
  localparam int DEF_V_ACTIVE = 600;
  localparam int DEF_V_FRONT  = 1;

  localparam bit DEF_SYNC_POL = 1'b1;

  function automatic int axis_total(input int sync_w, input int back_w,
                                    input int active_w, input int front_w);
    return sync_w + back_w + active_w + front_w;
  endfunction

  localparam int DEF_H_TOTAL = axis_total(DEF_H_SYNC, DEF_H_BACK, DEF_H_ACTIVE, DEF_H_FRONT);
  localparam int DEF_V_TOTAL = axis_total(DEF_V_SYNC, DEF_V_BACK, DEF_V_ACTIVE, DEF_V_FRONT);

endpackage

// File: rtl/vga_axis_counter.sv
// Wrapping 0..TOTAL-1 counter for one display axis, with enable and terminal-count flag.
// The next-state value is exported so the owner can register outputs on the same edge.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int TOTAL = DEF_H_TOTAL,
  parameter int W     = COORD_W
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  output logic [W-1:0] o_cnt_next,
  output logic         o_tc
);

  localparam logic [W-1:0] L_LAST = W'(TOTAL - 1);

  logic [W-1:0] r_cnt;

  assign o_tc = (r_cnt == L_LAST);

  always_comb begin
    o_cnt_next = r_cnt;
    if (i_en) begin
      o_cnt_next = o_tc ? '0 : r_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= o_cnt_next;
    end
  end

endmodule

// File: rtl/vga_sync_module.sv
// VGA timing generator: sync pulses, active-window strobe and pixel coordinates, all registered.
// Optional VGA_FRAME_CNT_EN adds a 16-bit free-running frame counter output.
module vga_sync_module
  import vga_timing_pkg::*;
#(
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BACK   = DEF_H_BACK,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FRONT  = DEF_H_FRONT,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BACK   = DEF_V_BACK,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FRONT  = DEF_V_FRONT,
  parameter bit SYNC_POL = DEF_SYNC_POL
) (
  input  logic               CLK,
  input  logic               RST,
  output logic               HSYNC_Sig,
  output logic               VSYNC_Sig,
  output logic               Ready_Sig,
  output logic [COORD_W-1:0] Column_Addr_Sig,
  output logic [COORD_W-1:0] Row_Addr_Sig,
  output logic               Frame_Start_Sig
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [FRAME_CNT_W-1:0] Frame_Cnt_Sig
`endif
);

  localparam int H_TOTAL = axis_total(H_SYNC, H_BACK, H_ACTIVE, H_FRONT);
  localparam int V_TOTAL = axis_total(V_SYNC, V_BACK, V_ACTIVE, V_FRONT);

  localparam logic [COORD_W-1:0] L_H_SYNC  = COORD_W'(H_SYNC);
  localparam logic [COORD_W-1:0] L_H_START = COORD_W'(H_SYNC + H_BACK);
  localparam logic [COORD_W-1:0] L_H_END   = COORD_W'(H_SYNC + H_BACK + H_ACTIVE - 1);
  localparam logic [COORD_W-1:0] L_V_SYNC  = COORD_W'(V_SYNC);
  localparam logic [COORD_W-1:0] L_V_START = COORD_W'(V_SYNC + V_BACK);
  localparam logic [COORD_W-1:0] L_V_END   = COORD_W'(V_SYNC + V_BACK + V_ACTIVE - 1);

  logic [COORD_W-1:0] w_h_next;
  logic [COORD_W-1:0] w_v_next;
  logic               w_h_tc;
  logic               w_v_tc;
  logic               w_in_h;
  logic               w_in_v;
  logic               w_active;

  vga_axis_counter #(
    .TOTAL (H_TOTAL),
    .W     (COORD_W)
  ) u_h_cnt (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_en       (1'b1),
    .o_cnt_next (w_h_next),
    .o_tc       (w_h_tc)
  );

  // The vertical axis only steps when the current line finishes.
  vga_axis_counter #(
    .TOTAL (V_TOTAL),
    .W     (COORD_W)
  ) u_v_cnt (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_en       (w_h_tc),
    .o_cnt_next (w_v_next),
    .o_tc       (w_v_tc)
  );

  assign w_in_h   = (w_h_next >= L_H_START) && (w_h_next <= L_H_END);
  assign w_in_v   = (w_v_next >= L_V_START) && (w_v_next <= L_V_END);
  assign w_active = w_in_h && w_in_v;

  // Outputs decode the next-state counters so they line up with the counter register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      HSYNC_Sig       <= SYNC_POL;
      VSYNC_Sig       <= SYNC_POL;
      Ready_Sig       <= 1'b0;
      Column_Addr_Sig <= '0;
      Row_Addr_Sig    <= '0;
      Frame_Start_Sig <= 1'b0;
    end else begin
      HSYNC_Sig       <= (w_h_next < L_H_SYNC) ? SYNC_POL : ~SYNC_POL;
      VSYNC_Sig       <= (w_v_next < L_V_SYNC) ? SYNC_POL : ~SYNC_POL;
      Ready_Sig       <= w_active;
      Column_Addr_Sig <= w_active ? (w_h_next - L_H_START) : '0;
      Row_Addr_Sig    <= w_active ? (w_v_next - L_V_START) : '0;
      Frame_Start_Sig <= (w_h_next == '0) && (w_v_next == '0);
    end
  end

`ifdef VGA_FRAME_CNT_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      Frame_Cnt_Sig <= '0;
    end else if (w_h_tc && w_v_tc) begin
      Frame_Cnt_Sig <= Frame_Cnt_Sig + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_sync_module.sv
// Directed bench: a default-timing instance for line/edge timing and a tiny-timing,
// active-low instance for whole-frame behaviour, sharing one clock and reset.
module tb_vga_sync_module;

  logic clk;
  logic rst;

  logic        d_hs, d_vs, d_rdy, d_fs;
  logic [10:0] d_col, d_row;
  logic        s_hs, s_vs, s_rdy, s_fs;
  logic [10:0] s_col, s_row;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] d_fc, s_fc;
`endif

  // Small instance: H = 3+2+6+2 = 13, V = 2+1+4+2 = 9, frame = 117 clocks.
  localparam int S_HT    = 13;
  localparam int S_VT    = 9;
  localparam int S_FRAME = S_HT * S_VT;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  vga_sync_module dut_d (
    .CLK             (clk),
    .RST             (rst),
    .HSYNC_Sig       (d_hs),
    .VSYNC_Sig       (d_vs),
    .Ready_Sig       (d_rdy),
    .Column_Addr_Sig (d_col),
    .Row_Addr_Sig    (d_row),
    .Frame_Start_Sig (d_fs)
`ifdef VGA_FRAME_CNT_EN
    ,
    .Frame_Cnt_Sig   (d_fc)
`endif
  );

  vga_sync_module #(
    .H_SYNC   (3),
    .H_BACK   (2),
    .H_ACTIVE (6),
    .H_FRONT  (2),
    .V_SYNC   (2),
    .V_BACK   (1),
    .V_ACTIVE (4),
    .V_FRONT  (2),
    .SYNC_POL (1'b0)
  ) dut_s (
    .CLK             (clk),
    .RST             (rst),
    .HSYNC_Sig       (s_hs),
    .VSYNC_Sig       (s_vs),
    .Ready_Sig       (s_rdy),
    .Column_Addr_Sig (s_col),
    .Row_Addr_Sig    (s_row),
    .Frame_Start_Sig (s_fs)
`ifdef VGA_FRAME_CNT_EN
    ,
    .Frame_Cnt_Sig   (s_fc)
`endif
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Leaves both instances at position 0 (the cycle after RST is sampled high).
  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic advance_to(input int n);
    while (cyc < n) tick();
  endtask

  function automatic logic [25:0] d_vec();
    return {d_hs, d_vs, d_rdy, d_fs, d_col, d_row};
  endfunction

  function automatic logic [25:0] s_vec();
    return {s_hs, s_vs, s_rdy, s_fs, s_col, s_row};
  endfunction

  function automatic logic [25:0] mk(input logic hs, input logic vs, input logic rdy,
                                     input logic fs, input int col, input int row);
    return {hs, vs, rdy, fs, 11'(col), 11'(row)};
  endfunction

  task automatic test_reset();
    logic [25:0] exp_v;
    do_reset();
    exp_v = mk(1, 1, 0, 0, 0, 0);
    n_tests++;
    if (d_vec() !== exp_v) begin
      n_fail++;
      $display("FAIL reset_default: got %h want %h", d_vec(), exp_v);
    end
    exp_v = mk(0, 0, 0, 0, 0, 0);
    n_tests++;
    if (s_vec() !== exp_v) begin
      n_fail++;
      $display("FAIL reset_small: got %h want %h", s_vec(), exp_v);
    end
  endtask

  task automatic test_hsync_width();
    int hi = 0;
    int lo = 0;
    int first_low = -1;
    do_reset();
    for (int i = 0; i < 1056; i++) begin
      if (i > 0) tick();
      if (d_hs === 1'b1) hi++;
      else begin
        lo++;
        if (first_low < 0) first_low = i;
      end
    end
    n_tests++;
    if (hi !== 128 || lo !== 928) begin
      n_fail++;
      $display("FAIL hsync_width: got hi=%0d lo=%0d want hi=128 lo=928", hi, lo);
    end
    n_tests++;
    if (first_low !== 128) begin
      n_fail++;
      $display("FAIL hsync_edge: got first low at %0d want 128", first_low);
    end
    tick();
    n_tests++;
    if (d_hs !== 1'b1) begin
      n_fail++;
      $display("FAIL hsync_next_line: got %b want 1", d_hs);
    end
  endtask

  task automatic test_active_edges();
    logic [25:0] exp_v;
    int pos[7];
    logic [25:0] exp_t[7];
    pos[0] = 4223;  exp_t[0] = mk(0, 1, 0, 0, 0, 0);
    pos[1] = 4224;  exp_t[1] = mk(1, 0, 0, 0, 0, 0);
    pos[2] = 28727; exp_t[2] = mk(0, 0, 0, 0, 0, 0);
    pos[3] = 28728; exp_t[3] = mk(0, 0, 1, 0, 0, 0);
    pos[4] = 29527; exp_t[4] = mk(0, 0, 1, 0, 799, 0);
    pos[5] = 29528; exp_t[5] = mk(0, 0, 0, 0, 0, 0);
    pos[6] = 29784; exp_t[6] = mk(0, 0, 1, 0, 0, 1);
    do_reset();
    for (int k = 0; k < 7; k++) begin
      advance_to(pos[k]);
      exp_v = exp_t[k];
      n_tests++;
      if (d_vec() !== exp_v) begin
        n_fail++;
        $display("FAIL active_edge@%0d: got %h want %h", pos[k], d_vec(), exp_v);
      end
    end
  endtask

  task automatic test_frame_walk();
    int h, v, errs, bad_at, fs_cnt, rdy_cnt, vs_cnt, hs_cnt, max_col, max_row;
    logic e_rdy;
    logic [25:0] exp_v;
    errs = 0; bad_at = -1; fs_cnt = 0; rdy_cnt = 0; vs_cnt = 0; hs_cnt = 0;
    max_col = 0; max_row = 0;
    do_reset();
    for (int n = 0; n <= 3 * S_FRAME; n++) begin
      if (n > 0) tick();
      h = n % S_HT;
      v = (n / S_HT) % S_VT;
      e_rdy = (h >= 5) && (h <= 10) && (v >= 3) && (v <= 6);
      exp_v = mk(h >= 3, v >= 2, e_rdy, (h == 0) && (v == 0) && (n != 0),
                 e_rdy ? h - 5 : 0, e_rdy ? v - 3 : 0);
      if (s_vec() !== exp_v) begin
        errs++;
        if (bad_at < 0) bad_at = n;
      end
      if (s_fs === 1'b1) fs_cnt++;
      if (n < S_FRAME) begin
        if (s_rdy === 1'b1) rdy_cnt++;
        if (s_vs === 1'b0) vs_cnt++;
        if (s_hs === 1'b0) hs_cnt++;
      end
      if (int'(s_col) > max_col) max_col = int'(s_col);
      if (int'(s_row) > max_row) max_row = int'(s_row);
      if (n == 88 || n == 89 || n == 96 || n == 116 || n == 117) begin
        n_tests++;
        if (s_vec() !== exp_v) begin
          n_fail++;
          $display("FAIL frame_point@%0d: got %h want %h", n, s_vec(), exp_v);
        end
      end
    end
    n_tests++;
    if (errs !== 0) begin
      n_fail++;
      $display("FAIL frame_walk: got %0d bad cycles (first %0d) want 0", errs, bad_at);
    end
    n_tests++;
    if (fs_cnt !== 3) begin
      n_fail++;
      $display("FAIL frame_start_count: got %0d want 3", fs_cnt);
    end
    n_tests++;
    if (rdy_cnt !== 24 || vs_cnt !== 26 || hs_cnt !== 27) begin
      n_fail++;
      $display("FAIL frame_counts: got rdy=%0d vs=%0d hs=%0d want 24 26 27", rdy_cnt, vs_cnt, hs_cnt);
    end
    n_tests++;
    if (max_col !== 5 || max_row !== 3) begin
      n_fail++;
      $display("FAIL coord_range: got col=%0d row=%0d want 5 3", max_col, max_row);
    end
  endtask

  task automatic test_mid_reset();
    logic [25:0] exp_v;
    do_reset();
    advance_to(72);
    exp_v = mk(1, 1, 1, 0, 2, 2);
    n_tests++;
    if (s_vec() !== exp_v) begin
      n_fail++;
      $display("FAIL pre_reset: got %h want %h", s_vec(), exp_v);
    end
    do_reset();
    exp_v = mk(0, 0, 0, 0, 0, 0);
    n_tests++;
    if (s_vec() !== exp_v) begin
      n_fail++;
      $display("FAIL mid_reset_small: got %h want %h", s_vec(), exp_v);
    end
    exp_v = mk(1, 1, 0, 0, 0, 0);
    n_tests++;
    if (d_vec() !== exp_v) begin
      n_fail++;
      $display("FAIL mid_reset_default: got %h want %h", d_vec(), exp_v);
    end
    advance_to(43);
    exp_v = mk(1, 1, 0, 0, 0, 0);
    n_tests++;
    if (s_vec() !== exp_v) begin
      n_fail++;
      $display("FAIL restart_pre_active: got %h want %h", s_vec(), exp_v);
    end
    tick();
    exp_v = mk(1, 1, 1, 0, 0, 0);
    n_tests++;
    if (s_vec() !== exp_v) begin
      n_fail++;
      $display("FAIL restart_first_active: got %h want %h", s_vec(), exp_v);
    end
    advance_to(S_FRAME);
    exp_v = mk(0, 0, 0, 1, 0, 0);
    n_tests++;
    if (s_vec() !== exp_v) begin
      n_fail++;
      $display("FAIL restart_frame_start: got %h want %h", s_vec(), exp_v);
    end
  endtask

`ifdef VGA_FRAME_CNT_EN
  task automatic test_frame_cnt();
    do_reset();
    n_tests++;
    if (s_fc !== 16'd0) begin
      n_fail++;
      $display("FAIL frame_cnt_reset: got %0d want 0", s_fc);
    end
    advance_to(3 * S_FRAME - 1);
    n_tests++;
    if (s_fc !== 16'd2) begin
      n_fail++;
      $display("FAIL frame_cnt_2: got %0d want 2", s_fc);
    end
    tick();
    n_tests++;
    if (s_fc !== 16'd3 || d_fc !== 16'd0) begin
      n_fail++;
      $display("FAIL frame_cnt_3: got s=%0d d=%0d want 3 0", s_fc, d_fc);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_hsync_width();
    test_active_edges();
    test_frame_walk();
    test_mid_reset();
`ifdef VGA_FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_sync_module.md
Name: vga_sync_module

Overview:
Timing generator for the VGA path. Produces HSYNC/VSYNC and the Ready_Sig, Column_Addr_Sig and Row_Addr_Sig strobes that the downstream pixel/ROM control logic consumes. Default mode is 800x600@60 Hz from a 40 MHz pixel clock. It sits between the clock source and the control module; the pins go straight to the connector.

Parameters:
H_SYNC, 128, horizontal sync width (clocks)
H_BACK, 88, horizontal back porch
H_ACTIVE, 800, visible pixels per line
H_FRONT, 40, horizontal front porch
V_SYNC, 4, vertical sync width (lines)
V_BACK, 23, vertical back porch
V_ACTIVE, 600, visible lines per frame
V_FRONT, 1, vertical front porch
SYNC_POL, 1, asserted level of HSYNC_Sig/VSYNC_Sig (1 = active-high)

Ports:
CLK  in  1  pixel clock
RST  in  1  synchronous reset, active-high
HSYNC_Sig  out  1  horizontal sync
VSYNC_Sig  out  1  vertical sync
Ready_Sig  out  1  high only while (h,v) is inside the active window
Column_Addr_Sig  out  11  active x coordinate; 0 when Ready_Sig=0
Row_Addr_Sig  out  11  active y coordinate; 0 when Ready_Sig=0
Frame_Start_Sig  out  1  one-cycle pulse at h=0, v=0

Behaviour:
- Clocking and reset: one clock, CLK. RST is synchronous and active-high.
- Totals: H_TOTAL = sum of the four H_* parameters (1056). V_TOTAL = sum of the four V_* parameters (628).
- h_cnt is 11 bits and counts 0..H_TOTAL-1, then wraps to 0.
- v_cnt is 11 bits and increments only on an h_cnt wrap. It counts 0..V_TOTAL-1, then wraps to 0.
- Region order per axis: sync, back porch, active, front porch, with sync starting at count 0.
- HSYNC_Sig = SYNC_POL when h_cnt < H_SYNC, else ~SYNC_POL. VSYNC_Sig follows the same rule using v_cnt and V_SYNC.
- Active window: h_cnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_ACTIVE-1] and v_cnt in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_ACTIVE-1].
- Inside the window: Column_Addr_Sig = h_cnt-(H_SYNC+H_BACK), Row_Addr_Sig = v_cnt-(V_SYNC+V_BACK). Outside it, both are 0.
- Frame_Start_Sig is 1 exactly when h_cnt=0 and v_cnt=0.
- All outputs are registered and glitch-free. Each output reflects the counter state of the same cycle: outputs are computed from the next-state counters and updated on the same edge as the counters.
- Reset state, in effect on the cycle after RST is sampled high:
  - h_cnt=0, v_cnt=0
  - HSYNC_Sig=SYNC_POL, VSYNC_Sig=SYNC_POL
  - Ready_Sig=0, Column_Addr_Sig=0, Row_Addr_Sig=0
  - Frame_Start_Sig=0, so the first frame is not flagged.
- After RST deasserts, counting starts from 0. The first Frame_Start_Sig pulse occurs after one full frame.
- RST asserted mid-frame or mid-line aborts the frame immediately. No partial-line completion.
- Line wrap and frame wrap occur on the same edge when h=H_TOTAL-1 and v=V_TOTAL-1: both counters go to 0.
- Boundary: the last active pixel (h=H_SYNC+H_BACK+H_ACTIVE-1) has Ready_Sig=1. The next clock has Ready_Sig=0 and Column_Addr_Sig=0.

Optional Feature:
VGA_FRAME_CNT_EN
- Defined: adds output Frame_Cnt_Sig [15:0]. It resets to 0, increments on every h/v double wrap, and wraps from 65535 to 0.
- Undefined: the port and its counter are absent. All other behaviour is identical.

Decomposition:
- Package vga_timing_pkg holds:
  - the default 800x600@60 timing constants, used as the parameter defaults
  - the 11-bit coordinate width constant
- One natural sub-module, vga_axis_counter, instantiated twice:
  - wrap counter with enable and terminal-count output
  - horizontal instance: enable=1
  - vertical instance: enable=horizontal terminal count

Test Plan:
- Reset release -> cycle 0: h=v=0, HSYNC_Sig=VSYNC_Sig=1, Ready_Sig=0. HSYNC_Sig stays 1 for exactly 128 clocks, then 0 for 928.
- Run one frame -> Frame_Start_Sig pulses every 663168 clocks. VSYNC_Sig is asserted for 4224 clocks (4 lines) per frame.
- Active-window edges:
  - First Ready_Sig=1 at clock 28728 after reset, with Column=0, Row=0.
  - At h=1015 on the same line, Column=799. At h=1016, Ready_Sig=0 and Column=0.
  - The last active line is Row=599 at v=626. v=627 has Ready_Sig=0.
- Count per frame -> exactly 480000 Ready_Sig-high clocks. Column and Row never exceed 799/599 and are 0 whenever Ready_Sig=0.
- Assert RST for 1 clock at v=300, h=500 -> next cycle all outputs are at reset values and counting restarts from h=v=0.
- With VGA_FRAME_CNT_EN: after 3 full frames, Frame_Cnt_Sig=3. A forced counter wrap from 65535 yields 0.
